// File: rtl/seg_state_pkg.sv
// Shared types, segment constants and decode helpers for the seven-segment state monitor.
package seg_state_pkg;

    localparam logic [1:0] ST_ATHENA = 2'd0;
    localparam logic [1:0] ST_BRAHMA = 2'd1;
    localparam logic [1:0] ST_CHRIST = 2'd2;
    localparam logic [1:0] ST_DEIMOS = 2'd3;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        FSM_IDLE,
        FSM_LOCKED
    } fsm_t;

    typedef enum logic [1:0] {
        PAT_DIGIT,
        PAT_BLANK,
        PAT_UNKNOWN
    } pat_kind_t;

    typedef struct packed {
        pat_kind_t  kind;
        logic [1:0] code;
    } seg_decode_t;

    // Any move back to ATHENA is allowed since it is the machine's reset target.
    function automatic logic legal_transition(input logic [1:0] from_code, input logic [1:0] to_code);
        logic ok;
        ok = 1'b0;
        if (to_code == ST_ATHENA)
            ok = 1'b1;
        else
            case (from_code)
                ST_ATHENA: ok = (to_code == ST_BRAHMA) || (to_code == ST_CHRIST);
                ST_BRAHMA: ok = (to_code == ST_CHRIST);
                ST_CHRIST: ok = (to_code == ST_DEIMOS);
                ST_DEIMOS: ok = (to_code == ST_CHRIST);
                default:   ok = 1'b0;
            endcase
        return ok;
    endfunction

    function automatic seg_decode_t seg_decode(input logic [6:0] seg);
        seg_decode_t d;
        d.kind = PAT_UNKNOWN;
        d.code = ST_ATHENA;
        case (seg)
            SEG_ZERO:  begin d.kind = PAT_DIGIT; d.code = ST_ATHENA; end
            SEG_ONE:   begin d.kind = PAT_DIGIT; d.code = ST_BRAHMA; end
            SEG_TWO:   begin d.kind = PAT_DIGIT; d.code = ST_CHRIST; end
            SEG_THREE: begin d.kind = PAT_DIGIT; d.code = ST_DEIMOS; end
            SEG_BLANK: d.kind = PAT_BLANK;
            default:   d.kind = PAT_UNKNOWN;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_state_monitor_if.sv
// Observation bundle between the segment source/observer and the state monitor.
interface seg_state_monitor_if;

    logic [6:0] SEG;
    logic       clear;
    logic [1:0] state;
    logic       valid;
    logic       change;
    logic       illegal_transition;
    logic       illegal_pattern;
    logic [7:0] trans_count;

    modport master (
        output SEG, clear,
        input  state, valid, change, illegal_transition, illegal_pattern, trans_count
    );

    modport slave (
        input  SEG, clear,
        output state, valid, change, illegal_transition, illegal_pattern, trans_count
    );

endinterface

// File: rtl/seg_stable_filter.sv
// Two-flop synchroniser plus stability filter; strobes accept once per stable run.
module seg_stable_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned WIDTH         = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pattern,
    output logic             accept
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [7:0]       cnt;
    logic [7:0]       cnt_next;
    logic             load;

    // Accept is decided from the counter's next value so the FSM acts on the same edge.
    always_comb begin
        load     = (s2 != cand);
        cnt_next = cnt;
        if (load)
            cnt_next = 8'd1;
        else if (cnt != STABLE)
            cnt_next = cnt + 8'd1;
        accept  = (cnt_next == STABLE) && (load || (cnt != STABLE));
        pattern = s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '1;
            s2   <= '1;
            cand <= '1;
            cnt  <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            cnt  <= cnt_next;
            if (load)
                cand <= s2;
        end
    end

endmodule

// File: rtl/seg_state_monitor.sv
// Decodes the filtered HEX0 pattern back to a state code and checks the transition graph.
module seg_state_monitor
    import seg_state_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    seg_state_monitor_if.slave mon
);

    logic [6:0]  acc_pat;
    logic        accept;
    seg_decode_t dec;

    fsm_t        fsm_q, fsm_d;
    logic [1:0]  state_q, state_d;
    logic        valid_q;
    logic        change_q, change_d;
    logic        it_q, it_d;
    logic        ip_q, ip_d;
    logic [7:0]  count_q, count_d;
    logic        set_it, set_ip, inc;

    seg_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .WIDTH         (7)
    ) u_filter (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .din     (mon.SEG),
        .pattern (acc_pat),
        .accept  (accept)
    );

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        change_d = 1'b0;
        set_it   = 1'b0;
        set_ip   = 1'b0;
        inc      = 1'b0;
        dec      = seg_decode(acc_pat);

        if (accept) begin
            case (fsm_q)
                FSM_IDLE: begin
                    case (dec.kind)
                        PAT_DIGIT: begin
                            state_d  = dec.code;
                            change_d = 1'b1;
                            fsm_d    = FSM_LOCKED;
                        end
                        PAT_UNKNOWN: set_ip = 1'b1;
                        default: ;
                    endcase
                end
                FSM_LOCKED: begin
                    case (dec.kind)
                        PAT_DIGIT: begin
                            if (dec.code != state_q) begin
                                state_d  = dec.code;
                                change_d = 1'b1;
                                if (legal_transition(state_q, dec.code))
                                    inc = 1'b1;
                                else
                                    set_it = 1'b1;
                            end
                        end
                        PAT_BLANK: fsm_d = FSM_IDLE;
                        default: begin
                            set_ip = 1'b1;
                            fsm_d  = FSM_IDLE;
                        end
                    endcase
                end
                default: fsm_d = FSM_IDLE;
            endcase
        end

        // Set/increment take priority over a coincident clear.
        it_d = set_it ? 1'b1 : (mon.clear ? 1'b0 : it_q);
        ip_d = set_ip ? 1'b1 : (mon.clear ? 1'b0 : ip_q);
        if (inc)
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        else if (mon.clear)
            count_d = '0;
        else
            count_d = count_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            fsm_q    <= FSM_IDLE;
            state_q  <= ST_ATHENA;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            it_q     <= 1'b0;
            ip_q     <= 1'b0;
            count_q  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            valid_q  <= (fsm_d == FSM_LOCKED);
            change_q <= change_d;
            it_q     <= it_d;
            ip_q     <= ip_d;
            count_q  <= count_d;
        end
    end

    assign mon.state              = state_q;
    assign mon.valid              = valid_q;
    assign mon.change             = change_q;
    assign mon.illegal_transition = it_q;
    assign mon.illegal_pattern    = ip_q;
    assign mon.trans_count        = count_q;

endmodule
